line_memory_responder: RTL



---
 rtl/line_memory_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/line_memory_responder.sv
// Line buffer serving one stored line per readLine request, with in-place write-back
// and a streaming flush of the whole buffer once every line has been served.
module line_memory_responder #(
    parameter int MEMSIZE = 25,
    parameter int DEPTH   = 32,
    parameter int CW      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid_i,
    input  logic [MEMSIZE-1:0] load_data_i,
    input  logic               load_last_i,
    output logic               load_ready_o,
    input  logic               readLine_i,
    output logic [MEMSIZE-1:0] line_o,
    output logic               line_valid_o,
    output logic [CW-1:0]      count_o,
    output logic               all_read_o,
    input  logic               writeLine_i,
    input  logic [MEMSIZE-1:0] wdata_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    output logic [MEMSIZE-1:0] out_data_o,
    output logic               out_last_o,
    input  logic               out_ready_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] LAST_SLOT = (CW+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW:0]        wptr_q, wptr_d;
    logic [CW-1:0]      rptr_q, rptr_d;
    logic [CW:0]        nlines_q, nlines_d;
    logic [MEMSIZE-1:0] line_q, line_d;
    logic               line_valid_q, line_valid_d;

    logic [MEMSIZE-1:0] mem_q [DEPTH];
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [MEMSIZE-1:0] mem_wdata;

    logic               all_read;
    logic [CW-1:0]      rptr_m1;

    assign all_read = (state_q != LOAD) && ({1'b0, rptr_q} == nlines_q);
    assign rptr_m1  = rptr_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        nlines_d     = nlines_q;
        line_d       = line_q;
        line_valid_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        load_ready_o = 1'b0;
        out_valid_o  = 1'b0;
        out_data_o   = '0;
        out_last_o   = 1'b0;

        case (state_q)
            LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    mem_we    = 1'b1;
                    mem_waddr = wptr_q[AW-1:0];
                    mem_wdata = load_data_i;
                    wptr_d    = wptr_q + 1'b1;
                    if (load_last_i || (wptr_q == LAST_SLOT)) begin
                        nlines_d = wptr_q + 1'b1;
                        rptr_d   = '0;
                        state_d  = SERVE;
                    end
                end
            end
            SERVE: begin
                if (readLine_i && !all_read) begin
                    line_d       = mem_q[rptr_q[AW-1:0]];
                    line_valid_d = 1'b1;
                    rptr_d       = rptr_q + 1'b1;
                end
                // write-back targets the line served most recently (pre-increment pointer)
                if (writeLine_i && (rptr_q != '0)) begin
                    mem_we    = 1'b1;
                    mem_waddr = rptr_m1[AW-1:0];
                    mem_wdata = wdata_i;
                end
                if (flush_i && all_read) begin
                    wptr_d  = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                out_valid_o = 1'b1;
                out_data_o  = mem_q[wptr_q[AW-1:0]];
                out_last_o  = (wptr_q == (nlines_q - 1'b1));
                if (out_ready_i) begin
                    if (out_last_o) begin
                        wptr_d   = '0;
                        rptr_d   = '0;
                        nlines_d = '0;
                        state_d  = LOAD;
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            wptr_q       <= '0;
            rptr_q       <= '0;
            nlines_q     <= '0;
            line_q       <= '0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            nlines_q     <= nlines_d;
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign line_o       = line_q;
    assign line_valid_o = line_valid_q;
    assign count_o      = rptr_q;
    assign all_read_o   = all_read;

endmodule
